// File: rtl/jt51_wrseq_pkg.sv
// Shared definitions for the jt51_wr_seq host write sequencer:
// FSM state encoding, counter widths and the saturating busy-counter helper.
package jt51_wrseq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    DATA,
    SETTLE,
    WAITB
  } state_t;

  localparam int CNT_W  = 4;
  localparam int BUSY_W = 10;

  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(4);

  // The busy counter must never wrap, so it sticks at all-ones.
  function automatic logic [BUSY_W-1:0] busy_inc(input logic [BUSY_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/jt51_wrseq_fifo.sv
// Synchronous command FIFO for jt51_wr_seq: 2**AW entries of {addr,data}.
// Status flags are registered from the next-cycle occupancy.
module jt51_wrseq_fifo #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [15:0]   wr_data,
  output logic [15:0]   rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  logic [15:0]   mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   next_level;

  // A push while full is still accepted when the same cycle pops a slot free.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    next_level = level;
    if (do_push && !do_pop)
      next_level = level + 1'b1;
    else if (!do_push && do_pop)
      next_level = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= next_level;
      full  <= (next_level == DEPTH);
      empty <= (next_level == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/jt51_wr_seq.sv
// Host-side JT51 write sequencer: FIFO-buffered address/data write pairs with busy handshake.
// Optional macro JT51_WRSEQ_SKIP_ADDR_EN skips the address phase when the register address repeats.
module jt51_wr_seq
  import jt51_wrseq_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int WR_LEN  = 1,
  parameter int GAP_LEN = 2,
  parameter int BUSY_TO = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_addr,
  input  logic [7:0]       cmd_data,
  input  logic             busy,
  output logic [7:0]       din,
  output logic             write,
  output logic             a0,
  output logic             idle,
  output logic             timeout,
  output logic [FIFO_AW:0] level
);

  localparam logic [CNT_W-1:0]  WR_L   = CNT_W'(WR_LEN);
  localparam logic [CNT_W-1:0]  GAP_L  = CNT_W'(GAP_LEN);
  localparam logic [BUSY_W-1:0] BUSY_L = BUSY_W'(BUSY_TO);
  localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BUSY_W-1:0] busy_cnt;
  logic [BUSY_W-1:0] busy_nxt;
  logic [7:0]        data_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [15:0]       fifo_rd;

`ifdef JT51_WRSEQ_SKIP_ADDR_EN
  logic [7:0] last_addr;
  logic       last_valid;
`endif

  assign cmd_ready = ~fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign idle      = fifo_empty && (state == IDLE);
  assign busy_nxt  = busy_inc(busy_cnt);

  jt51_wrseq_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid & cmd_ready),
    .pop     (pop),
    .wr_data ({cmd_addr, cmd_data}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_cnt <= '0;
      data_q   <= '0;
      din      <= '0;
      write    <= 1'b0;
      a0       <= 1'b0;
      timeout  <= 1'b0;
`ifdef JT51_WRSEQ_SKIP_ADDR_EN
      last_addr  <= 8'h00;
      last_valid <= 1'b0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          write <= 1'b0;
          a0    <= 1'b0;
          if (!fifo_empty) begin
            data_q <= fifo_rd[7:0];
            cnt    <= ONE;
            write  <= 1'b1;
`ifdef JT51_WRSEQ_SKIP_ADDR_EN
            if (last_valid && (last_addr == fifo_rd[15:8])) begin
              state <= DATA;
              din   <= fifo_rd[7:0];
              a0    <= 1'b1;
            end else begin
              state      <= ADDR;
              din        <= fifo_rd[15:8];
              last_addr  <= fifo_rd[15:8];
              last_valid <= 1'b1;
            end
`else
            state <= ADDR;
            din   <= fifo_rd[15:8];
`endif
          end
        end
        ADDR: begin
          if (cnt == WR_L) begin
            cnt <= ONE;
            // Without a gap the strobe stays high and only a0/din change.
            if (GAP_L == '0) begin
              state <= DATA;
              din   <= data_q;
              a0    <= 1'b1;
              write <= 1'b1;
            end else begin
              state <= GAP;
              write <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_L) begin
            state <= DATA;
            cnt   <= ONE;
            din   <= data_q;
            a0    <= 1'b1;
            write <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == WR_L) begin
            state <= SETTLE;
            cnt   <= ONE;
            write <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (busy || (cnt == SETTLE_MAX)) begin
            state    <= WAITB;
            busy_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAITB: begin
          if (!busy) begin
            state <= IDLE;
            a0    <= 1'b0;
          end else begin
            busy_cnt <= busy_nxt;
            if (busy_nxt == BUSY_L) begin
              timeout <= 1'b1;
              state   <= IDLE;
              a0      <= 1'b0;
`ifdef JT51_WRSEQ_SKIP_ADDR_EN
              last_valid <= 1'b0;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt51_wr_seq.sv
// Self-checking bench for jt51_wr_seq: scoreboard of expected bus writes plus a busy model.
// Honours JT51_WRSEQ_SKIP_ADDR_EN when the design is built with it.
module tb_jt51_wr_seq;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       busy;
  logic [7:0] din;
  logic       write;
  logic       a0;
  logic       idle;
  logic       timeout;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_mode = 0;  // 0 normal 32-cycle busy, 1 stuck high, 2 never
  int hold = 0;
  int wr_count = 0;
  int addr_wr_count = 0;
  int to_count = 0;
  int data_start_cyc = 0;
  logic pw = 1'b0;
  logic pa0 = 1'b0;
  logic new_wr;
  logic [8:0] want;
  logic [8:0] sb[$];

`ifdef JT51_WRSEQ_SKIP_ADDR_EN
  logic [7:0] m_last = 8'h00;
  logic       m_valid = 1'b0;
`endif

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] exp_level;
    logic       exp_ready;
  } vec_t;
  vec_t vecs[9];

  jt51_wr_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .din       (din),
    .write     (write),
    .a0        (a0),
    .idle      (idle),
    .timeout   (timeout),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, scoreboard compare and busy model, all sampled mid-cycle.
  always @(negedge clk) begin
    new_wr = write && (!pw || (a0 != pa0));
    if (timeout) to_count++;
    if (new_wr) begin
      wr_count++;
      if (!a0) addr_wr_count++;
      else data_start_cyc = cyc;
      if (busy_mode == 0) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL write_while_busy: busy=%0b required 0", busy);
        end
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got a0=%0b din=%02h, required none", a0, din);
      end else begin
        want = sb.pop_front();
        if ({a0, din} !== want) begin
          errors++;
          $display("[TB] FAIL bus_write: got a0=%0b din=%02h, required a0=%0b din=%02h",
                   a0, din, want[8], want[7:0]);
        end
      end
    end
    case (busy_mode)
      0: begin
        if (new_wr && a0) begin
          hold = 32;
          busy = 1'b1;
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) busy = 1'b0;
        end
      end
      1: if (new_wr && a0) busy = 1'b1;
      default: busy = 1'b0;
    endcase
    pw  = write;
    pa0 = a0;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_wait: cmd_ready=0 after %0d cycles, required 1", n);
    end else begin
`ifdef JT51_WRSEQ_SKIP_ADDR_EN
      if (!(m_valid && m_last == a)) sb.push_back({1'b0, a});
      m_last  = a;
      m_valid = 1'b1;
`else
      sb.push_back({1'b0, a});
`endif
      sb.push_back({1'b1, d});
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int limit);
    int n = 0;
    while (!idle && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, idle, 1);
  endtask

  initial begin
    int snap;
    for (int i = 0; i < 9; i++) begin
      vecs[i].addr      = 8'h10 + 8'(i);
      vecs[i].data      = 8'hA0 + 8'(3 * i);
      vecs[i].exp_level = (i == 0) ? 4'd1 : 4'(i);
      vecs[i].exp_ready = (i < 8);
    end

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_write", write, 0);
    checkOutput("rst_din", din, 0);
    checkOutput("rst_a0", a0, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_idle", idle, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single pair: write rises on the pop edge that follows the push edge.
    applyStimulus(8'h08, 8'h78);
    checkOutput("lat_write_push_edge", write, 0);
    checkOutput("lat_idle_push_edge", idle, 0);
    @(posedge clk); #1;
    checkOutput("lat_write_pop_edge", write, 1);
    checkOutput("lat_a0", a0, 0);
    checkOutput("lat_din", din, 8'h08);
    waitIdle("single_idle", 200);
    checkOutput("single_sb_empty", sb.size(), 0);

    // Nine back-to-back commands: one is popped early, so the ninth fills the FIFO.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("fill_level_%0d", i), level, vecs[i].exp_level);
      checkOutput($sformatf("fill_ready_%0d", i), cmd_ready, vecs[i].exp_ready);
    end
    waitIdle("burst_idle", 2000);
    checkOutput("burst_sb_empty", sb.size(), 0);

    // Busy stuck high: WR_LEN + one SETTLE cycle + 1023 WAITB cycles to the pulse.
    busy_mode = 1;
    applyStimulus(8'h30, 8'h11);
    applyStimulus(8'h31, 8'h22);
    snap = 0;
    while (!timeout && snap < 1200) begin
      @(posedge clk); #1;
      snap++;
    end
    checkOutput("timeout_seen", timeout, 1);
    checkOutput("timeout_delay", 16'(cyc - data_start_cyc), 16'd1025);
    busy_mode = 0;
    busy = 1'b0;
    hold = 0;
    @(posedge clk); #1;
    checkOutput("timeout_width", timeout, 0);
    waitIdle("after_timeout_idle", 300);
    checkOutput("after_timeout_sb_empty", sb.size(), 0);

    // Busy never rises: WR_LEN + 4 SETTLE cycles + 1 WAITB cycle.
    busy_mode = 2;
    applyStimulus(8'h40, 8'h55);
    waitIdle("nobusy_idle", 100);
    checkOutput("nobusy_delay", 16'(cyc - data_start_cyc), 16'd6);
    checkOutput("nobusy_no_timeout", to_count, 1);

    // Reset during the data phase.
    busy_mode = 0;
    applyStimulus(8'h50, 8'h66);
    applyStimulus(8'h51, 8'h77);
    snap = 0;
    while (!(write && a0) && snap < 50) begin
      @(posedge clk); #1;
      snap++;
    end
    checkOutput("reach_data_phase", write & a0, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_write", write, 0);
    checkOutput("midrst_level", level, 0);
    checkOutput("midrst_idle", idle, 1);
    checkOutput("midrst_din", din, 0);
    rst_n = 1'b1;
    sb.delete();
`ifdef JT51_WRSEQ_SKIP_ADDR_EN
    m_valid = 1'b0;
`endif
    snap = wr_count;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("midrst_no_writes", 16'(wr_count - snap), 0);

    // Repeated address: the second write skips the address phase only in the skip build.
    snap = addr_wr_count;
    applyStimulus(8'h20, 8'hC7);
    applyStimulus(8'h20, 8'h00);
    applyStimulus(8'h28, 8'h4A);
    waitIdle("skip_idle", 500);
`ifdef JT51_WRSEQ_SKIP_ADDR_EN
    checkOutput("skip_addr_strobes", 16'(addr_wr_count - snap), 2);
`else
    checkOutput("skip_addr_strobes", 16'(addr_wr_count - snap), 3);
`endif
    checkOutput("final_sb_empty", sb.size(), 0);
    checkOutput("final_timeouts", to_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
